// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and fifo write-port bundle for fifo_wr_arbiter.
// Signal names carry the arbiter's direction view: *_i is driven into the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 8
);
  logic [N_REQ*DWIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ-1:0]        grant_o;
  logic [DWIDTH-1:0]       fifo_data_o;
  logic                    fifo_wrreq_o;
  logic [AWIDTH:0]         fifo_usedw_i;

  // Requesters plus fifo: everything the arbiter consumes.
  modport master (
    output req_data_i, req_valid_i, fifo_usedw_i,
    input  req_ready_o, grant_o, fifo_data_o, fifo_wrreq_o
  );

  // The arbiter itself.
  modport slave (
    input  req_data_i, req_valid_i, fifo_usedw_i,
    output req_ready_o, grant_o, fifo_data_o, fifo_wrreq_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N requesters share one fifo write port, one owner at a time
// for bursts of up to BURST_LEN words. Writes are registered; fill level guards overflow.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned AWIDTH    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input logic            clk_i,
  input logic            arstn_i,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam logic [AWIDTH+1:0] Depth = {2'b01, {AWIDTH{1'b0}}};

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IdxW-1:0]   ptr_q;     // last owner; also the current owner while granted
  logic [CntW-1:0]   cnt_q;
  logic [DWIDTH-1:0] data_q;
  logic              wrreq_q;

  logic [AWIDTH+1:0] fill;
  logic              space_ok;
  logic [N_REQ-1:0]  ready;
  logic              xfer;
  logic              owner_valid;
  logic [DWIDTH-1:0] owner_data;
  logic              found;
  logic [IdxW-1:0]   next_idx;
  logic [IdxW-1:0]   cand;

  // The registered write not yet seen by the fifo counts as occupied.
  assign fill     = {1'b0, bus.fifo_usedw_i} + {{(AWIDTH+1){1'b0}}, wrreq_q};
  assign space_ok = fill < Depth;
  assign ready    = grant_q & {N_REQ{space_ok}};
  // ready is already one-hot gated by the grant, so any hit is the owner.
  assign xfer        = |(bus.req_valid_i & ready);
  assign owner_valid = bus.req_valid_i[ptr_q];

  assign bus.req_ready_o  = ready;
  assign bus.grant_o      = grant_q;
  assign bus.fifo_data_o  = data_q;
  assign bus.fifo_wrreq_o = wrreq_q;

  // Select the current owner's data slice.
  always_comb begin
    owner_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ptr_q == IdxW'(k)) begin
        owner_data = bus.req_data_i[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // Round-robin search from ptr+1; scanning farthest-first lets the nearest hit win.
  always_comb begin
    found    = 1'b0;
    next_idx = ptr_q;
    cand     = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      cand = IdxW'((32'(ptr_q) + i) % N_REQ);
      if (bus.req_valid_i[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  // Arbitration FSM with registered grant and fifo write outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= IdxW'(N_REQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      wrreq_q <= 1'b0;
    end else begin
      wrreq_q <= xfer;
      if (xfer) begin
        data_q <= owner_data;
      end
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << next_idx;
            ptr_q   <= next_idx;
            cnt_q   <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (!owner_valid) begin
            grant_q <= '0;
            state_q <= StIdle;
          end else if (xfer) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(BURST_LEN - 1)) begin
              grant_q <= '0;
              state_q <= StIdle;
            end
          end
          // Valid owner without fifo space: hold grant and count.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
